reg_write_scheduler: RTL

Write-port scheduler and busy-bit scoreboard for the decode-stage register file. It shares the file's single write port between two writeback requesters, the ALU and the memory/load path, using round-robin arbitration with valid/ready handshakes. It tracks which registers have a write in flight, so decode stalls operand reads (RAW) and destination allocation (WAW). It sits between the writeback stage and the register file and drives the file's `reg_wr`/`reg_wr_addr`/`reg_wr_data` inputs.

---
 rtl/reg_sched_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/reg_write_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/reg_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
//   DEF_NUM_REGS / DEF_ADDR_W / DEF_DATA_W : default geometry
//   req_e    : writeback requester identity (ALU = 0, MEM = 1)
//   wb_req_t : one writeback request (valid, addr, data) at default widths
package reg_sched_pkg;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_DATA_W   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset (async, active low)
//   req[1:0]   : request vector, bit 0 = ALU, bit 1 = MEM
//   grant[1:0] : one-hot grant (combinational from req and last winner)
// On contention the requester that did not win most recently is granted.
// After reset the last winner is MEM, so ALU wins the first contention.
module rr_arb2
  import reg_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_e last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= REQ_MEM;
    end else if (grant[0]) begin
      last <= REQ_ALU;
    end else if (grant[1]) begin
      last <= REQ_MEM;
    end
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_MEM) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/reg_write_scheduler.sv
// Write-port scheduler and busy-bit scoreboard for the decode-stage
// register file.
//   clk, reset (async, active low)
//   alloc_valid/alloc_addr/alloc_ready : decode marks a destination pending
//   rd_addr1/rd_addr2/rd_stall         : decode source operand busy check
//   alu_wb_* / mem_wb_*                : writeback requesters (valid/ready)
//   reg_wr/reg_wr_addr/reg_wr_data     : registered register-file write port
//   busy_vec                           : registered scoreboard
// Optional macro REG_WRITE_SCHED_R0_ZERO_EN: register 0 is hardwired zero,
// never marked busy, and writebacks to it are granted but not written.
module reg_write_scheduler
  import reg_sched_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid,
  input  logic [ADDR_W-1:0]   alloc_addr,
  output logic                alloc_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                rd_stall,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_addr,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                mem_wb_valid,
  input  logic [ADDR_W-1:0]   mem_wb_addr,
  input  logic [DATA_W-1:0]   mem_wb_data,
  output logic                mem_wb_ready,
  output logic                reg_wr,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [DATA_W-1:0]   reg_wr_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;
  logic [1:0]          grant;
  logic                win;
  logic                wr_en;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({mem_wb_valid, alu_wb_valid}),
    .grant (grant)
  );

  assign alu_wb_ready = grant[0];
  assign mem_wb_ready = grant[1];
  assign busy_vec     = busy;

  always_comb begin
    alloc_ready = !busy[alloc_addr];
`ifdef REG_WRITE_SCHED_R0_ZERO_EN
    if (alloc_addr == '0) alloc_ready = 1'b1;
`endif
    rd_stall = busy[rd_addr1] | busy[rd_addr2];

    win      = |grant;
    win_addr = grant[1] ? mem_wb_addr : alu_wb_addr;
    win_data = grant[1] ? mem_wb_data : alu_wb_data;
`ifdef REG_WRITE_SCHED_R0_ZERO_EN
    wr_en = win && (win_addr != '0);
`else
    wr_en = win;
`endif

    set_vec = '0;
    clr_vec = '0;
    if (alloc_valid && alloc_ready) set_vec[alloc_addr] = 1'b1;
    if (win)                        clr_vec[win_addr]   = 1'b1;
    // Set is applied after clear so a same-cycle alloc keeps the bit high.
    busy_next = (busy & ~clr_vec) | set_vec;
`ifdef REG_WRITE_SCHED_R0_ZERO_EN
    busy_next[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
    end else begin
      busy   <= busy_next;
      reg_wr <= wr_en;
      if (win) begin
        reg_wr_addr <= win_addr;
        reg_wr_data <= win_data;
      end
    end
  end

endmodule
